ula_arbiter: RTL

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - two-requester round-robin arbiter sharing one external combinational ULA
// Three-state FSM: IDLE arbitrates and latches operands, ISSUE captures the ULA, HOLD waits for release.
module ula_arbiter (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       req0,
  input  logic       req1,
  input  logic       sel0,
  input  logic       sel1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       ovf,
  output logic       ula_sel,
  output logic [3:0] ula_a,
  output logic [3:0] ula_b,
  input  logic [3:0] ula_s,
  input  logic       ula_ovf,
  output logic       busy,
  output logic [7:0] ops_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t     state, state_n;
  logic       cur, cur_n;
  logic       last_ptr, last_ptr_n;
  logic       win, req_cur;
  logic       gnt0_n, gnt1_n, done0_n, done1_n;
  logic [3:0] result_n;
  logic       ovf_n;
  logic       ula_sel_n;
  logic [3:0] ula_a_n, ula_b_n;
  logic       busy_n;
  logic [7:0] ops_cnt_n;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      cur      <= 1'b0;
      last_ptr <= 1'b1;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      result   <= 4'd0;
      ovf      <= 1'b0;
      ula_sel  <= 1'b0;
      ula_a    <= 4'd0;
      ula_b    <= 4'd0;
      busy     <= 1'b0;
      ops_cnt  <= 8'd0;
    end else begin
      state    <= state_n;
      cur      <= cur_n;
      last_ptr <= last_ptr_n;
      gnt0     <= gnt0_n;
      gnt1     <= gnt1_n;
      done0    <= done0_n;
      done1    <= done1_n;
      result   <= result_n;
      ovf      <= ovf_n;
      ula_sel  <= ula_sel_n;
      ula_a    <= ula_a_n;
      ula_b    <= ula_b_n;
      busy     <= busy_n;
      ops_cnt  <= ops_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    last_ptr_n = last_ptr;
    gnt0_n     = gnt0;
    gnt1_n     = gnt1;
    done0_n    = done0;
    done1_n    = done1;
    result_n   = result;
    ovf_n      = ovf;
    ula_sel_n  = ula_sel;
    ula_a_n    = ula_a;
    ula_b_n    = ula_b;
    ops_cnt_n  = ops_cnt;
    // On a tie the requester not served last wins; otherwise the sole requester.
    win        = (req0 && req1) ? ~last_ptr : req1;
    req_cur    = cur ? req1 : req0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_n   = ISSUE;
          cur_n     = win;
          gnt0_n    = ~win;
          gnt1_n    = win;
          ula_sel_n = win ? sel1 : sel0;
          ula_a_n   = win ? a1 : a0;
          ula_b_n   = win ? b1 : b0;
        end
      end
      ISSUE: begin
        state_n   = HOLD;
        result_n  = ula_s;
        ovf_n     = ula_ovf;
        done0_n   = ~cur;
        done1_n   = cur;
        ops_cnt_n = ops_cnt + 8'd1;
      end
      HOLD: begin
        if (!req_cur) begin
          state_n    = IDLE;
          gnt0_n     = 1'b0;
          gnt1_n     = 1'b0;
          done0_n    = 1'b0;
          done1_n    = 1'b0;
          last_ptr_n = cur;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
